// File: rtl/bcd_score_accum.sv
// BCD line-clear score accumulator: adds level-scaled base points one digit per cycle.
// Optional SCORE_HISCORE_EN adds a high-score register cleared only by RESET.
module bcd_score_accum #(
    parameter int NUM_DIGITS      = 6,
    parameter int LEVEL_W         = 4,
    parameter int LINES_PER_LEVEL = 10
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    new_game,
    input  logic                    line_valid,
    input  logic [2:0]              num_lines,
    output logic                    ready,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [LEVEL_W-1:0]      level,
`ifdef SCORE_HISCORE_EN
    output logic [4*NUM_DIGITS-1:0] hiscore,
`endif
    output logic                    overflow
);

    localparam int SW = 4 * NUM_DIGITS;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = LEVEL_W + 1;

    // state  | meaning
    // IDLE   | waiting for an event, ready=1
    // ADD    | adding base into working score, one digit per cycle
    // COMMIT | results visible, done=1
    typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   work_q, work_d;
    logic [15:0]     base_q, base_d;
    logic [PW-1:0]   pass_q, pass_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [2:0]      nl_q, nl_d;
    logic [SW-1:0]   digits_q, digits_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [7:0]      lines_q, lines_d;
    logic            ovf_q, ovf_d;
`ifdef SCORE_HISCORE_EN
    logic [SW-1:0]   hi_q, hi_d;
`endif

    logic [SW-1:0]   base_full;
    logic [4:0]      dsum;
    logic            cout;
    logic [8:0]      lsum;
    int              di;

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        base_d    = base_q;
        pass_d    = pass_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        nl_d      = nl_q;
        digits_d  = digits_q;
        level_d   = level_q;
        lines_d   = lines_q;
        ovf_d     = ovf_q;
`ifdef SCORE_HISCORE_EN
        hi_d      = hi_q;
`endif
        base_full = '0;
        base_full[15:0] = base_q;
        dsum      = '0;
        cout      = 1'b0;
        lsum      = '0;
        di        = int'(idx_q);

        case (state_q)
            S_IDLE: begin
                if (line_valid && num_lines >= 3'd1 && num_lines <= 3'd4) begin
                    state_d = S_ADD;
                    work_d  = digits_q;
                    pass_d  = {1'b0, level_q} + PW'(1);
                    idx_d   = '0;
                    carry_d = 1'b0;
                    nl_d    = num_lines;
                    case (num_lines)
                        3'd1:    base_d = 16'h0040;
                        3'd2:    base_d = 16'h0100;
                        3'd3:    base_d = 16'h0300;
                        default: base_d = 16'h1200;
                    endcase
                end
            end
            S_ADD: begin
                dsum = {1'b0, work_q[di*4 +: 4]} + {1'b0, base_full[di*4 +: 4]} + {4'd0, carry_q};
                if (dsum > 5'd9) begin
                    dsum = dsum - 5'd10;
                    cout = 1'b1;
                end
                work_d[di*4 +: 4] = dsum[3:0];
                if (idx_q == IW'(NUM_DIGITS - 1)) begin
                    if (cout) work_d = {NUM_DIGITS{4'h9}};
                    if (cout || pass_q == PW'(1)) begin
                        // Results land on the edge into COMMIT so they appear alongside done.
                        state_d  = S_COMMIT;
                        digits_d = work_d;
                        ovf_d    = ovf_q | cout;
                        lsum     = {1'b0, lines_q} + {6'd0, nl_q};
                        if (lsum >= 9'(LINES_PER_LEVEL)) begin
                            lines_d = 8'(lsum - 9'(LINES_PER_LEVEL));
                            if (level_q != '1) level_d = level_q + 1'b1;
                        end else begin
                            lines_d = lsum[7:0];
                        end
`ifdef SCORE_HISCORE_EN
                        if (work_d > hi_q) hi_d = work_d;
`endif
                    end else begin
                        pass_d  = pass_q - PW'(1);
                        idx_d   = '0;
                        carry_d = 1'b0;
                    end
                end else begin
                    idx_d   = idx_q + 1'b1;
                    carry_d = cout;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (new_game) begin
            state_d  = S_IDLE;
            digits_d = '0;
            level_d  = '0;
            lines_d  = '0;
            ovf_d    = 1'b0;
`ifdef SCORE_HISCORE_EN
            hi_d     = hi_q;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            base_q   <= '0;
            pass_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            nl_q     <= '0;
            digits_q <= '0;
            level_q  <= '0;
            lines_q  <= '0;
            ovf_q    <= 1'b0;
`ifdef SCORE_HISCORE_EN
            hi_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            base_q   <= base_d;
            pass_q   <= pass_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            nl_q     <= nl_d;
            digits_q <= digits_d;
            level_q  <= level_d;
            lines_q  <= lines_d;
            ovf_q    <= ovf_d;
`ifdef SCORE_HISCORE_EN
            hi_q     <= hi_d;
`endif
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_COMMIT);
    assign digits   = digits_q;
    assign level    = level_q;
    assign overflow = ovf_q;
`ifdef SCORE_HISCORE_EN
    assign hiscore  = hi_q;
`endif

endmodule
